// File: rtl/basket_score_ctrl.sv
// Basketball score controller: synchronised key inputs, round-robin team grant and BCD score increment.
// Optional key debounce is compiled in with the DEBOUNCE_EN macro.
module basket_score_ctrl #(
    parameter int DB_CYCLES = 16
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic [2:0]  key_a,
    input  logic [2:0]  key_b,
    input  logic        clr,
    output logic [15:0] score,
    output logic        busy,
    output logic        upd,
    output logic        upd_team,
    output logic [1:0]  sat
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [5:0]  sync1_r;
    logic [5:0]  sync2_r;
    logic [5:0]  prev_r;
    logic [5:0]  clean_s;
    logic [5:0]  rise_s;
    logic [1:0]  pend_a_r;
    logic [1:0]  pend_b_r;
    logic [1:0]  new_a_s;
    logic [1:0]  new_b_s;
    logic [1:0]  cnt_r;
    logic        team_r;
    logic        last_b_r;
    logic        svc_a_s;
    logic        svc_b_s;

    // Highest pressed value of one team wins.
    function automatic logic [1:0] key_points(input logic [2:0] k);
        logic [1:0] p;
        if (k[2]) begin
            p = 2'd3;
        end else if (k[1]) begin
            p = 2'd2;
        end else if (k[0]) begin
            p = 2'd1;
        end else begin
            p = 2'd0;
        end
        return p;
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Debounce length must be positive; empty block documents the constraint.
    if (DB_CYCLES < 1) begin : g_db_cycles_invalid
    end

    // Two-flop synchroniser and edge-detector history; bits [5:3] team A, [2:0] team B.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 6'd0;
            sync2_r <= 6'd0;
            prev_r  <= 6'd0;
        end else begin
            sync1_r <= {key_a, key_b};
            sync2_r <= sync1_r;
            prev_r  <= clean_s;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
    localparam logic [DBW-1:0] DB_ONE  = DBW'(1);

    logic [5:0]     db_q_r;
    logic [DBW-1:0] db_cnt_r [6];

    // A new level is accepted only after DB_CYCLES consecutive differing samples.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            db_q_r <= 6'd0;
            for (int i = 0; i < 6; i++) begin
                db_cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (sync2_r[i] == db_q_r[i]) begin
                    db_cnt_r[i] <= '0;
                end else if (db_cnt_r[i] == DB_LAST) begin
                    db_q_r[i]   <= sync2_r[i];
                    db_cnt_r[i] <= '0;
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
                end
            end
        end
    end

    assign clean_s = db_q_r;
`else
    assign clean_s = sync2_r;
`endif

    // Rising edges, per-team point value and in-service indication.
    always_comb begin
        rise_s  = clean_s & ~prev_r;
        new_a_s = key_points(rise_s[5:3]);
        new_b_s = key_points(rise_s[2:0]);
        svc_a_s = (state_r != IDLE) && !team_r;
        svc_b_s = (state_r != IDLE) && team_r;
    end

    // Pending capture, grant arbitration, BCD increment and update signalling.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            score    <= 16'h0000;
            busy     <= 1'b0;
            upd      <= 1'b0;
            upd_team <= 1'b0;
            sat      <= 2'b00;
            pend_a_r <= 2'd0;
            pend_b_r <= 2'd0;
            cnt_r    <= 2'd0;
            team_r   <= 1'b0;
            last_b_r <= 1'b1;
        end else if (clr) begin
            state_r  <= IDLE;
            score    <= 16'h0000;
            busy     <= 1'b0;
            upd      <= 1'b0;
            sat      <= 2'b00;
            pend_a_r <= 2'd0;
            pend_b_r <= 2'd0;
            cnt_r    <= 2'd0;
        end else begin
            upd <= 1'b0;
            // Edges are dropped while the team is pending or being served.
            if ((pend_a_r == 2'd0) && !svc_a_s && (new_a_s != 2'd0)) begin
                pend_a_r <= new_a_s;
            end else begin
                pend_a_r <= pend_a_r;
            end
            if ((pend_b_r == 2'd0) && !svc_b_s && (new_b_s != 2'd0)) begin
                pend_b_r <= new_b_s;
            end else begin
                pend_b_r <= pend_b_r;
            end
            case (state_r)
                IDLE: begin
                    if ((pend_a_r != 2'd0) && ((pend_b_r == 2'd0) || last_b_r)) begin
                        team_r   <= 1'b0;
                        last_b_r <= 1'b0;
                        cnt_r    <= pend_a_r;
                        pend_a_r <= 2'd0;
                        state_r  <= INC;
                        busy     <= 1'b1;
                    end else if (pend_b_r != 2'd0) begin
                        team_r   <= 1'b1;
                        last_b_r <= 1'b1;
                        cnt_r    <= pend_b_r;
                        pend_b_r <= 2'd0;
                        state_r  <= INC;
                        busy     <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                INC: begin
                    if (!team_r) begin
                        if (score[15:8] == 8'h99) begin
                            sat[1] <= 1'b1;
                        end else begin
                            score[15:8] <= bcd_inc(score[15:8]);
                        end
                    end else begin
                        if (score[7:0] == 8'h99) begin
                            sat[0] <= 1'b1;
                        end else begin
                            score[7:0] <= bcd_inc(score[7:0]);
                        end
                    end
                    cnt_r <= cnt_r - 2'd1;
                    busy  <= 1'b1;
                    if (cnt_r == 2'd1) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= INC;
                    end
                end
                DONE: begin
                    state_r  <= IDLE;
                    busy     <= 1'b0;
                    upd      <= 1'b1;
                    upd_team <= team_r;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_basket_score_ctrl.sv
// Directed self-checking bench for basket_score_ctrl; expected values are hand-computed constants.
module tb_basket_score_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b0;
    logic [2:0]  key_a  = 3'b000;
    logic [2:0]  key_b  = 3'b000;
    logic        clr    = 1'b0;
    logic [15:0] score;
    logic        busy;
    logic        upd;
    logic        upd_team;
    logic [1:0]  sat;

    int n_checks = 0;
    int n_fail   = 0;

    basket_score_ctrl #(.DB_CYCLES(16)) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .key_a    (key_a),
        .key_b    (key_b),
        .clr      (clr),
        .score    (score),
        .busy     (busy),
        .upd      (upd),
        .upd_team (upd_team),
        .sat      (sat)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic wait_upd(input int max_cyc, output logic found, output logic team);
        found = 1'b0;
        team  = 1'b0;
        for (int i = 0; i < max_cyc && !found; i++) begin
            tick();
            if (upd === 1'b1) begin
                found = 1'b1;
                team  = upd_team;
            end
        end
    endtask

    task automatic press(input logic [2:0] a, input logic [2:0] b);
        key_a = a;
        key_b = b;
        repeat (4) tick();
        key_a = 3'b000;
        key_b = 3'b000;
    endtask

    task automatic serve(input string tag, input logic [2:0] a, input logic [2:0] b,
                         input logic exp_team, input logic [15:0] exp_score);
        logic f;
        logic t;
        press(a, b);
        wait_upd(40, f, t);
        check({tag, "_upd_seen"}, {15'd0, f}, 16'd1);
        check({tag, "_team"}, {15'd0, t}, {15'd0, exp_team});
        check({tag, "_score"}, score, exp_score);
        tick();
    endtask

    task automatic wait_busy(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (busy === 1'b1) begin
                seen = 1'b1;
            end
        end
        check({tag, "_busy_seen"}, {15'd0, seen}, 16'd1);
    endtask

    initial begin
        logic f;
        logic t;
        int   n_upd;

        repeat (2) @(negedge clk_in);
        check("rst_score", score, 16'h0000);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_upd", {15'd0, upd}, 16'd0);
        check("rst_upd_team", {15'd0, upd_team}, 16'd0);
        check("rst_sat", {14'd0, sat}, 16'd0);
        rst_n = 1'b1;
        tick();

`ifdef DEBOUNCE_EN
        // 10-cycle glitch must be filtered.
        key_a = 3'b001;
        repeat (10) tick();
        key_a = 3'b000;
        n_upd = 0;
        repeat (40) begin
            tick();
            if (upd === 1'b1) n_upd++;
        end
        check("db_glitch_upd", n_upd[15:0], 16'd0);
        check("db_glitch_score", score, 16'h0000);
        key_a = 3'b001;
        repeat (20) tick();
        key_a = 3'b000;
        wait_upd(40, f, t);
        check("db_clean_upd_seen", {15'd0, f}, 16'd1);
        check("db_clean_score", score, 16'h0100);
        n_upd = 0;
        repeat (30) begin
            tick();
            if (upd === 1'b1) n_upd++;
        end
        check("db_clean_extra_upd", n_upd[15:0], 16'd0);
        check("db_clean_final", score, 16'h0100);
`else
        // +2 for A with cycle-exact timing: grant on 4th edge, score final 2 edges later.
        key_a = 3'b010;
        repeat (3) tick();
        check("t_pre_grant_busy", {15'd0, busy}, 16'd0);
        tick();
        check("t_grant_busy", {15'd0, busy}, 16'd1);
        check("t_grant_score", score, 16'h0000);
        key_a = 3'b000;
        tick();
        check("t_inc1_score", score, 16'h0100);
        tick();
        check("t_inc2_score", score, 16'h0200);
        check("t_inc2_upd", {15'd0, upd}, 16'd0);
        tick();
        check("t_upd", {15'd0, upd}, 16'd1);
        check("t_upd_team", {15'd0, upd_team}, 16'd0);
        check("t_done_busy", {15'd0, busy}, 16'd0);
        tick();
        check("t_upd_pulse_end", {15'd0, upd}, 16'd0);

        serve("multi_bit", 3'b011, 3'b000, 1'b0, 16'h0400);
        serve("a_plus3", 3'b100, 3'b000, 1'b0, 16'h0700);
        serve("a_plus2", 3'b010, 3'b000, 1'b0, 16'h0900);
        serve("bcd_carry", 3'b001, 3'b000, 1'b0, 16'h1000);

        for (int i = 0; i < 29; i++) begin
            press(3'b100, 3'b000);
            wait_upd(40, f, t);
            tick();
        end
        check("climb_score", score, 16'h9700);
        serve("to_98", 3'b001, 3'b000, 1'b0, 16'h9800);
        check("no_sat_98", {14'd0, sat}, 16'd0);
        serve("to_99", 3'b100, 3'b000, 1'b0, 16'h9900);
        check("sat_a", {14'd0, sat}, 16'h0002);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_score", score, 16'h0000);
        check("clr_sat", {14'd0, sat}, 16'd0);

        // Asynchronous reset mid-increment.
        key_a = 3'b100;
        wait_busy("rst_mid");
        tick();
        check("rst_mid_partial", score, 16'h0100);
        key_a = 3'b000;
        rst_n = 1'b0;
        #1;
        check("rst_mid_score", score, 16'h0000);
        check("rst_mid_busy", {15'd0, busy}, 16'd0);
        @(negedge clk_in);
        rst_n = 1'b1;
        tick();

        // Simultaneous A and B: A first after reset, then B.
        press(3'b100, 3'b001);
        wait_upd(40, f, t);
        check("rr_first_seen", {15'd0, f}, 16'd1);
        check("rr_first_team", {15'd0, t}, 16'd0);
        check("rr_first_score", score, 16'h0300);
        wait_upd(40, f, t);
        check("rr_second_seen", {15'd0, f}, 16'd1);
        check("rr_second_team", {15'd0, t}, 16'd1);
        check("rr_second_score", score, 16'h0301);
        tick();

        // clr during INC of a +3 for A.
        key_a = 3'b100;
        wait_busy("clr_inc");
        tick();
        check("clr_inc_partial", score, 16'h0401);
        clr   = 1'b1;
        key_a = 3'b000;
        tick();
        clr = 1'b0;
        check("clr_inc_score", score, 16'h0000);
        check("clr_inc_busy", {15'd0, busy}, 16'd0);
        n_upd = (upd === 1'b1) ? 1 : 0;
        repeat (10) begin
            tick();
            if (upd === 1'b1) n_upd++;
        end
        check("clr_inc_no_upd", n_upd[15:0], 16'd0);

        // key_b[0] pressed twice; the second rise lands while B is in service.
        key_b = 3'b001;
        tick();
        key_b = 3'b000;
        tick();
        key_b = 3'b001;
        repeat (3) tick();
        key_b = 3'b000;
        wait_upd(40, f, t);
        check("dbl_upd_seen", {15'd0, f}, 16'd1);
        check("dbl_team", {15'd0, t}, 16'd1);
        check("dbl_score", score, 16'h0001);
        n_upd = 0;
        repeat (15) begin
            tick();
            if (upd === 1'b1) n_upd++;
        end
        check("dbl_extra_upd", n_upd[15:0], 16'd0);
        check("dbl_final_score", score, 16'h0001);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
